// File: rtl/cpu6502_addr_bus.sv
// Address-bus datapath: ADL/ADH byte selection, the ADH byte offered to the PCH select,
// and the ABL/ABH external address register pair.
module cpu6502_addr_bus #(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [2:0]  i_adl_sel,
    input  logic [2:0]  i_adh_sel,
    input  logic        i_load_abl,
    input  logic        i_load_abh,
    input  logic [7:0]  i_data_i,
    input  logic [7:0]  i_alu,
    input  logic [7:0]  i_pcls,
    input  logic [7:0]  i_pchs,
    input  logic [7:0]  i_reg_s,
    input  logic [7:0]  i_vector_lo,
    output logic [7:0]  o_adl_abl,
    output logic [7:0]  o_adh_abh,
    output logic [7:0]  o_adh_pchs,
    output logic [15:0] o_address
);

    localparam logic [2:0] ADL_PC  = 3'd0;
    localparam logic [2:0] ADL_DI  = 3'd1;
    localparam logic [2:0] ADL_S   = 3'd2;
    localparam logic [2:0] ADL_ALU = 3'd3;
    localparam logic [2:0] ADL_VEC = 3'd4;

    localparam logic [2:0] ADH_PC  = 3'd0;
    localparam logic [2:0] ADH_DI  = 3'd1;
    localparam logic [2:0] ADH_ALU = 3'd2;
    localparam logic [2:0] ADH_ZP  = 3'd3;
    localparam logic [2:0] ADH_STK = 3'd4;
    localparam logic [2:0] ADH_VEC = 3'd5;

    logic [7:0] w_adl;
    logic [7:0] w_adh;
    logic [7:0] w_adh_pchs;
    logic [7:0] r_abl;
    logic [7:0] r_abh;

    always_comb begin
        w_adl = 8'h00;
        case (i_adl_sel)
            ADL_PC:  w_adl = i_pcls;
            ADL_DI:  w_adl = i_data_i;
            ADL_S:   w_adl = i_reg_s;
            ADL_ALU: w_adl = i_alu;
            ADL_VEC: w_adl = i_vector_lo;
            default: w_adl = 8'h00;
        endcase
    end

    // Fixed pages: zero page, stack page 1, and page FF for vector fetches.
    always_comb begin
        w_adh = 8'h00;
        case (i_adh_sel)
            ADH_PC:  w_adh = i_pchs;
            ADH_DI:  w_adh = i_data_i;
            ADH_ALU: w_adh = i_alu;
            ADH_ZP:  w_adh = 8'h00;
            ADH_STK: w_adh = 8'h01;
            ADH_VEC: w_adh = 8'hFF;
            default: w_adh = 8'h00;
        endcase
    end

    // PCH reload comes from the ALU only for indexed/relative results; otherwise
    // from the data bus (jump targets, return addresses, vector high byte).
    always_comb begin
        w_adh_pchs = i_data_i;
        if (i_adh_sel == ADH_ALU) begin
            w_adh_pchs = i_alu;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_abl <= RESET_ADDR[7:0];
            r_abh <= RESET_ADDR[15:8];
        end else begin
            if (i_load_abl) begin
                r_abl <= w_adl;
            end
            if (i_load_abh) begin
                r_abh <= w_adh;
            end
        end
    end

    assign o_adl_abl  = w_adl;
    assign o_adh_abh  = w_adh;
    assign o_adh_pchs = w_adh_pchs;
    assign o_address  = {r_abh, r_abl};

endmodule

// File: tb/tb_cpu6502_addr_bus.sv
// Directed self-checking bench for cpu6502_addr_bus: hand-computed expected bytes and
// addresses checked with immediate assertions.
module tb_cpu6502_addr_bus;

    logic        clk;
    logic        reset;
    logic [2:0]  adl_sel;
    logic [2:0]  adh_sel;
    logic        load_abl;
    logic        load_abh;
    logic [7:0]  data_i;
    logic [7:0]  alu;
    logic [7:0]  pcls;
    logic [7:0]  pchs;
    logic [7:0]  reg_s;
    logic [7:0]  vector_lo;
    logic [7:0]  adl_abl;
    logic [7:0]  adh_abh;
    logic [7:0]  adh_pchs;
    logic [15:0] address;

    int n_checks = 0;
    int n_fail   = 0;

    cpu6502_addr_bus #(.RESET_ADDR(16'h0000)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_adl_sel   (adl_sel),
        .i_adh_sel   (adh_sel),
        .i_load_abl  (load_abl),
        .i_load_abh  (load_abh),
        .i_data_i    (data_i),
        .i_alu       (alu),
        .i_pcls      (pcls),
        .i_pchs      (pchs),
        .i_reg_s     (reg_s),
        .i_vector_lo (vector_lo),
        .o_adl_abl   (adl_abl),
        .o_adh_abh   (adh_abh),
        .o_adh_pchs  (adh_pchs),
        .o_address   (address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Distinct byte on every source so a wrong select shows up.
        reset = 1'b1; load_abl = 1'b1; load_abh = 1'b1;
        adl_sel = 3'd1; adh_sel = 3'd1;
        data_i = 8'h5A; alu = 8'hA5; pcls = 8'h21; pchs = 8'h43;
        reg_s = 8'h65; vector_lo = 8'h87;
        #2;
        chk("adl_di_in_reset", {8'h00, adl_abl}, 16'h005A);
        tick();
        chk("reset_addr", address, 16'h0000);
        chk("adl_follows_in_reset", {8'h00, adl_abl}, 16'h005A);

        #3;
        reset = 1'b0;
        adl_sel = 3'd0; pcls = 8'h34; adh_sel = 3'd0; pchs = 8'h12;
        #1;
        chk("adl_pc", {8'h00, adl_abl}, 16'h0034);
        chk("adh_pc", {8'h00, adh_abh}, 16'h0012);
        chk("pchs_default_di", {8'h00, adh_pchs}, 16'h005A);
        tick();
        chk("addr_pc", address, 16'h1234);

        adl_sel = 3'd2; reg_s = 8'hFD; adh_sel = 3'd4;
        tick();
        chk("addr_stack", address, 16'h01FD);

        load_abh = 1'b0; adl_sel = 3'd3; alu = 8'hFC; adh_sel = 3'd0;
        tick();
        chk("addr_abl_only", address, 16'h01FC);

        load_abh = 1'b1; adl_sel = 3'd4; vector_lo = 8'hFE; adh_sel = 3'd5;
        #1;
        chk("adl_vec", {8'h00, adl_abl}, 16'h00FE);
        chk("adh_vec", {8'h00, adh_abh}, 16'h00FF);
        tick();
        chk("addr_vec", address, 16'hFFFE);

        load_abl = 1'b0; load_abh = 1'b0;
        adh_sel = 3'd2; alu = 8'h80; data_i = 8'h11;
        #1;
        chk("pchs_alu", {8'h00, adh_pchs}, 16'h0080);
        chk("adh_alu", {8'h00, adh_abh}, 16'h0080);
        adh_sel = 3'd1;
        #1;
        chk("pchs_di", {8'h00, adh_pchs}, 16'h0011);
        chk("adh_di", {8'h00, adh_abh}, 16'h0011);

        adl_sel = 3'd7; adh_sel = 3'd6;
        #1;
        chk("adl_sel7_zero", {8'h00, adl_abl}, 16'h0000);
        chk("adh_sel6_zero", {8'h00, adh_abh}, 16'h0000);
        tick();
        chk("addr_hold", address, 16'hFFFE);

        adl_sel = 3'd5; adh_sel = 3'd3;
        #1;
        chk("adl_sel5_zero", {8'h00, adl_abl}, 16'h0000);
        chk("adh_zp", {8'h00, adh_abh}, 16'h0000);
        adl_sel = 3'd6; adh_sel = 3'd7;
        #1;
        chk("adl_sel6_zero", {8'h00, adl_abl}, 16'h0000);
        chk("adh_sel7_zero", {8'h00, adh_abh}, 16'h0000);

        load_abh = 1'b1; adh_sel = 3'd1; data_i = 8'h11;
        tick();
        chk("addr_abh_only", address, 16'h11FE);

        adl_sel = 3'd1; data_i = 8'h3C; adh_sel = 3'd0; pchs = 8'h7E;
        load_abl = 1'b1; load_abh = 1'b0;
        tick();
        chk("addr_zp_abl_keep_page", address, 16'h113C);

        reset = 1'b1; load_abl = 1'b1; load_abh = 1'b1;
        tick();
        chk("reset_mid_op", address, 16'h0000);
        chk("adh_follows_in_reset", {8'h00, adh_abh}, 16'h007E);

        reset = 1'b0;
        tick();
        chk("post_reset_load", address, 16'h7E3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
